gold_nic: RTL and testbench
===========================

Name: gold_nic

Overview:
- Network interface controller that sits between one processing element (PE) and the PE port of `gold_router`.
- Processor side: a 4-register memory-mapped interface.
- Network side: drives the router's PE input channel (pesi/peri/pedi) and sinks the router's PE output channel (peso/pero/pedo).
- Holds one output-channel buffer and one input-channel buffer.
- Gates injection on the router's `polarity` so that a packet enters only on its matching virtual channel.

Parameters:
PACKET_SIZE, 64, packet width in bits; bit 63 = VC, bit 62 = direction (0 = cw, 1 = ccw), bits 55:48 = hop count.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low
addr  input  2  register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
d_in  input  PACKET_SIZE  processor write data
d_out  output  PACKET_SIZE  processor read data, registered
nicEn  input  1  access enable
nicWrEn  input  1  1 = write, 0 = read; valid only with nicEn
net_so  output  1  send to router PE input (router pesi)
net_ri  input  1  router ready for PE input (router peri)
net_do  output  PACKET_SIZE  packet to router (router pedi)
net_polarity  input  1  router polarity
net_si  input  1  router delivering packet (router peso)
net_ro  output  1  NIC ready to accept (router pero)
net_di  input  PACKET_SIZE  packet from router (router pedo)

Behaviour:
Reset (reset = 0, async):
- out_buf, in_buf, d_out and both full flags = 0.
- Resulting outputs: net_so = 0, net_ro = 1, net_do = 0, d_out = 0.

Output channel (processor to router):
- Write to out_buf: nicEn & nicWrEn & addr == 10.
  - Accepted only if out_full = 0 at that edge; loads d_in and sets out_full.
  - If out_full = 1, the write is silently dropped and out_buf is unchanged.
- net_do = out_buf, combinational.
- net_so = out_full & (out_buf[63] == net_polarity), combinational.
- Transfer: at a rising edge with net_so & net_ri, out_full clears.
- A write in the same cycle as a transfer is dropped, because out_full was 1 at that edge.
- If the polarity does not match, the packet waits; there is no timeout.

Input channel (router to processor):
- net_ro = ~in_full, combinational.
- Capture: at a rising edge with net_si & net_ro, in_buf <= net_di and in_full sets.
- Read of in_buf: nicEn & ~nicWrEn & addr == 00.
  - d_out <= in_buf at the edge.
  - in_full clears at the same edge.
  - No capture can collide with the read, since net_ro = 0 while full.
- A read of in_buf while empty returns stale in_buf and leaves in_full = 0.

Status reads (d_out updates one cycle after the request edge):
- addr 01: d_out <= {zeros, in_full}.
- addr 11: d_out <= {zeros, out_full}.
- Read of addr 10: d_out <= 0.
- Write to addr 00/01/11: ignored.

d_out:
- Holds its value when there is no read.
- Read latency is 1 cycle; throughput is one access per cycle.

Mid-operation reset: buffers are discarded immediately; no partial handshake survives.

Optional Feature:
Macro NIC_STAT_EN.
- Defined:
  - Two 16-bit counters: tx_cnt increments on each network-side transfer out; rx_cnt increments on each capture in.
  - Both wrap 0xFFFF to 0x0000 and reset to 0.
  - Status reads place the count in d_out[31:16]: addr 01 returns rx_cnt, addr 11 returns tx_cnt.
- Undefined: d_out[31:16] of status reads = 0 and no counter logic exists.

Test Plan:
- Reset release, idle → net_so = 0, net_ro = 1, d_out = 0; status reads at 01 and 11 return 0.
- Write 64'h0007_0000_0001_1111 (VC 0) to addr 10, net_ri = 1, polarity toggling → net_so asserts only while polarity = 0; out_full clears after that edge; addr 11 read returns 0.
- Write a VC 1 packet while net_ri = 0 for 5 cycles, then a second write → second write dropped; after net_ri = 1 on polarity = 1, net_do equals the first packet.
- Drive net_si = 1, net_di = 64'h4000_0000_0002_2222 → net_ro falls the next cycle; a second net_si is ignored; addr 01 reads 1; addr 00 read returns 64'h4000_0000_0002_2222 one cycle later and net_ro returns to 1.
- Assert reset low mid-transfer with out_full = 1 and in_full = 1 → net_so = 0 and net_ro = 1 immediately, without waiting for a clock edge.
- With NIC_STAT_EN: 3 tx and 2 rx transfers → addr 11 read d_out[31:16] = 3, addr 01 read d_out[31:16] = 2.

Source files
------------

// File: rtl/gold_nic.sv
// gold_nic: single-entry in/out buffered NIC between a PE and the gold_router PE port.
// Define NIC_STAT_EN to add 16-bit tx/rx transfer counters reported in status reads.
module gold_nic #(
  parameter int PACKET_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             addr,
  input  logic [PACKET_SIZE-1:0] d_in,
  output logic [PACKET_SIZE-1:0] d_out,
  input  logic                   nicEn,
  input  logic                   nicWrEn,
  output logic                   net_so,
  input  logic                   net_ri,
  output logic [PACKET_SIZE-1:0] net_do,
  input  logic                   net_polarity,
  input  logic                   net_si,
  output logic                   net_ro,
  input  logic [PACKET_SIZE-1:0] net_di
);

  localparam logic [1:0] A_IN_BUF  = 2'b00;
  localparam logic [1:0] A_IN_STAT = 2'b01;
  localparam logic [1:0] A_OUT_BUF = 2'b10;
  localparam logic [1:0] A_OUT_STAT = 2'b11;

  logic [PACKET_SIZE-1:0] r_out_buf, r_in_buf, r_d_out;
  logic                   r_out_full, r_in_full;
  logic                   w_wr_out, w_rd, w_rd_in, w_tx, w_rx;
  logic [PACKET_SIZE-1:0] w_in_stat, w_out_stat;

  assign w_wr_out = nicEn & nicWrEn & (addr == A_OUT_BUF);
  assign w_rd     = nicEn & ~nicWrEn;
  assign w_rd_in  = w_rd & (addr == A_IN_BUF);

  // A packet may only enter on the VC the router is currently accepting.
  assign net_so = r_out_full & (r_out_buf[PACKET_SIZE-1] == net_polarity);
  assign net_do = r_out_buf;
  assign net_ro = ~r_in_full;
  assign w_tx   = net_so & net_ri;
  assign w_rx   = net_si & net_ro;
  assign d_out  = r_d_out;

  // w_tx implies r_out_full, so a write racing a transfer is naturally dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_tx) begin
      r_out_full <= 1'b0;
    end else if (w_wr_out && !r_out_full) begin
      r_out_buf  <= d_in;
      r_out_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_rx) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_rd_in) begin
      r_in_full <= 1'b0;
    end
  end

`ifdef NIC_STAT_EN
  logic [15:0] r_tx_cnt, r_rx_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx) r_tx_cnt <= r_tx_cnt + 16'd1;
      if (w_rx) r_rx_cnt <= r_rx_cnt + 16'd1;
    end
  end

  always_comb begin
    w_in_stat         = '0;
    w_out_stat        = '0;
    w_in_stat[0]      = r_in_full;
    w_out_stat[0]     = r_out_full;
    w_in_stat[31:16]  = r_rx_cnt;
    w_out_stat[31:16] = r_tx_cnt;
  end
`else
  always_comb begin
    w_in_stat     = '0;
    w_out_stat    = '0;
    w_in_stat[0]  = r_in_full;
    w_out_stat[0] = r_out_full;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      case (addr)
        A_IN_BUF:   r_d_out <= r_in_buf;
        A_IN_STAT:  r_d_out <= w_in_stat;
        A_OUT_BUF:  r_d_out <= '0;
        A_OUT_STAT: r_d_out <= w_out_stat;
        default:    r_d_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gold_nic.sv
// Self-checking bench for gold_nic: table of register accesses plus handshake/reset sequences.
module tb_gold_nic;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out, net_do, net_di;
  logic        nicEn, nicWrEn, net_so, net_ri, net_polarity, net_si, net_ro;

  gold_nic #(.PACKET_SIZE(64)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ri(net_ri),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ro(net_ro), .net_di(net_di)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } sb_t;

  typedef struct {
    bit          wr;
    logic [1:0]  a;
    logic [63:0] d;
    logic [63:0] exp;
    string       name;
  } vec_t;

  sb_t         sbq[$];
  vec_t        tbl[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] model_dout;
  logic [15:0] m_tx, m_rx;

  localparam logic [63:0] PA = 64'h8000_0000_0000_AAAA;
  localparam logic [63:0] PB = 64'h8000_0000_0000_BBBB;
  localparam logic [63:0] PP = 64'h0007_0000_0001_1111;
  localparam logic [63:0] PQ = 64'h0003_0000_0000_3333;
  localparam logic [63:0] PR = 64'h0004_0000_0000_4444;
  localparam logic [63:0] PD = 64'h4000_0000_0002_2222;
  localparam logic [63:0] PE = 64'h4000_0000_0005_5555;

  function automatic logic [63:0] stat(input logic [15:0] c, input logic f);
    logic [63:0] v;
    v    = '0;
    v[0] = f;
`ifdef NIC_STAT_EN
    v[31:16] = c;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop;
    sb_t e;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sbq.pop_front();
      check(e.name, d_out, e.exp);
    end
  endtask

  // One-cycle register access; reads update the expected d_out, writes expect it held.
  task automatic access(input bit wr, input logic [1:0] a, input logic [63:0] d,
                        input logic [63:0] exp, input string name);
    sb_t e;
    nicEn = 1'b1; nicWrEn = wr; addr = a; d_in = d;
    if (!wr) model_dout = exp;
    e.name = name;
    e.exp  = model_dout;
    sbq.push_back(e);
    step;
    nicEn = 1'b0; nicWrEn = 1'b0;
    sb_pop;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ri = 1'b0; net_polarity = 1'b0; net_si = 1'b0; net_di = '0;
    model_dout = '0; m_tx = '0; m_rx = '0;

    tbl.push_back('{0, 2'b01, 64'h0, stat(0, 0), "rd_in_stat_idle"});
    tbl.push_back('{0, 2'b11, 64'h0, stat(0, 0), "rd_out_stat_idle"});
    tbl.push_back('{0, 2'b00, 64'h0, 64'h0,      "rd_in_buf_empty"});
    tbl.push_back('{0, 2'b10, 64'h0, 64'h0,      "rd_out_buf_zero"});
    tbl.push_back('{1, 2'b10, PA,    64'h0,      "wr_out_a_hold"});
    tbl.push_back('{0, 2'b11, 64'h0, stat(0, 1), "rd_out_stat_full"});
    tbl.push_back('{1, 2'b10, PB,    64'h0,      "wr_out_b_drop_hold"});
    tbl.push_back('{1, 2'b00, PE,    64'h0,      "wr_addr00_ignored"});
    tbl.push_back('{1, 2'b01, PE,    64'h0,      "wr_addr01_ignored"});
    tbl.push_back('{1, 2'b11, PE,    64'h0,      "wr_addr11_ignored"});
    tbl.push_back('{0, 2'b01, 64'h0, stat(0, 0), "rd_in_stat_still0"});
    tbl.push_back('{0, 2'b10, 64'h0, 64'h0,      "rd_out_buf_zero2"});
    tbl.push_back('{0, 2'b11, 64'h0, stat(0, 1), "rd_out_stat_full2"});

    step; step;
    check("rst_net_so", {63'h0, net_so}, 64'h0);
    check("rst_net_ro", {63'h0, net_ro}, 64'h1);
    check("rst_net_do", net_do, 64'h0);
    check("rst_d_out",  d_out,  64'h0);
    reset = 1'b1;
    step;

    for (int i = 0; i < tbl.size(); i++)
      access(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp, tbl[i].name);
    check("drop_keeps_first", net_do, PA);
    check("vc1_pol0_blocked", {63'h0, net_so}, 64'h0);

    // VC1 packet waits on ri=0, then leaves once the router is ready
    net_polarity = 1'b1; #1;
    check("vc1_pol1_so", {63'h0, net_so}, 64'h1);
    step; step;
    check("vc1_wait_ri0", {63'h0, net_so}, 64'h1);
    net_ri = 1'b1;
    step; m_tx++;
    check("vc1_sent_so", {63'h0, net_so}, 64'h0);
    access(0, 2'b11, 64'h0, stat(m_tx, 0), "rd_out_stat_after_tx");

    // VC0 packet with polarity toggling
    net_polarity = 1'b0;
    access(1, 2'b10, PP, 64'h0, "wr_out_p");
    net_polarity = 1'b1; #1;
    check("vc0_pol1_so", {63'h0, net_so}, 64'h0);
    step;
    check("vc0_pol1_held", {63'h0, net_so}, 64'h0);
    net_polarity = 1'b0; #1;
    check("vc0_pol0_so", {63'h0, net_so}, 64'h1);
    check("vc0_net_do", net_do, PP);
    step; m_tx++;
    check("vc0_sent_so", {63'h0, net_so}, 64'h0);
    access(0, 2'b11, 64'h0, stat(m_tx, 0), "rd_out_stat_vc0");

    // write racing a transfer is dropped
    net_polarity = 1'b1;
    access(1, 2'b10, PQ, 64'h0, "wr_out_q");
    net_polarity = 1'b0;
    access(1, 2'b10, PR, 64'h0, "wr_out_r_race"); m_tx++;
    check("race_so_clear", {63'h0, net_so}, 64'h0);
    check("race_buf_q", net_do, PQ);
    net_ri = 1'b0;

    // input channel capture and back-pressure
    net_si = 1'b1; net_di = PD; #1;
    check("in_ro_ready", {63'h0, net_ro}, 64'h1);
    step; m_rx++;
    check("in_ro_low", {63'h0, net_ro}, 64'h0);
    net_di = PE;
    step; step;
    check("in_ro_still_low", {63'h0, net_ro}, 64'h0);
    net_si = 1'b0;
    access(0, 2'b01, 64'h0, stat(m_rx, 1), "rd_in_stat_full");
    access(0, 2'b00, 64'h0, PD,            "rd_in_buf_d");
    check("in_ro_back", {63'h0, net_ro}, 64'h1);
    access(0, 2'b01, 64'h0, stat(m_rx, 0), "rd_in_stat_cleared");
    access(0, 2'b00, 64'h0, PD,            "rd_in_buf_stale");

    // asynchronous reset with both buffers occupied
    net_polarity = 1'b1;
    access(1, 2'b10, PQ, 64'h0, "wr_out_before_rst");
    net_si = 1'b1; net_di = PE;
    step; net_si = 1'b0;
    net_polarity = 1'b0; #1;
    check("pre_rst_so", {63'h0, net_so}, 64'h1);
    check("pre_rst_ro", {63'h0, net_ro}, 64'h0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_so",   {63'h0, net_so}, 64'h0);
    check("async_rst_ro",   {63'h0, net_ro}, 64'h1);
    check("async_rst_do",   net_do, 64'h0);
    check("async_rst_dout", d_out,  64'h0);
    m_tx = '0; m_rx = '0; model_dout = '0;
    step; reset = 1'b1; step;

    // transfer counting: 3 out, 2 in
    net_ri = 1'b1; net_polarity = 1'b0;
    for (int i = 0; i < 3; i++) begin
      access(1, 2'b10, PP + 64'(i), 64'h0, "wr_out_cnt");
      step; m_tx++;
    end
    net_ri = 1'b0;
    for (int i = 0; i < 2; i++) begin
      net_si = 1'b1; net_di = PD + 64'(i);
      step; m_rx++; net_si = 1'b0;
      access(0, 2'b00, 64'h0, PD + 64'(i), "rd_in_cnt");
    end
    access(0, 2'b11, 64'h0, stat(m_tx, 0), "rd_tx_count");
    access(0, 2'b01, 64'h0, stat(m_rx, 0), "rd_rx_count");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
